// File: rtl/sram_ctrl.sv
// Bridges the MEM-stage request bus to a 16-bit asynchronous SRAM: each word is split into beats with programmable wait states.
// Optional per-byte write masking is enabled by defining SRAM_CTRL_BYTE_EN_EN (adds the mem_byte_en port).
`timescale 1ns/1ps

module sram_ctrl #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DQ_W   = 16,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            mem_addr,
  input  logic [DATA_W-1:0]      mem_wdata,
`ifdef SRAM_CTRL_BYTE_EN_EN
  input  logic [DATA_W/8-1:0]    mem_byte_en,
`endif
  output logic [DATA_W-1:0]      mem_rdata,
  output logic                   mem_ready,
  inout  wire  [SRAM_DQ_W-1:0]   sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n
);

  localparam int BEATS      = DATA_W / SRAM_DQ_W;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
  localparam int BE_W       = DATA_W / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  state_t                 r_state, w_next_state;
  logic [BEAT_W-1:0]      r_beat, w_next_beat;
  logic [3:0]             r_wait, w_next_wait;
  logic                   r_write, w_next_write;
  logic [SRAM_ADDR_W-1:0] r_base, w_next_base;
  logic [DATA_W-1:0]      r_wdata, w_next_wdata;
  logic [BE_W-1:0]        r_be, w_next_be, w_be_in;
  logic                   w_req, w_beat_end, w_last_beat;
  logic [31:0]            w_index;
  logic [SRAM_DQ_W-1:0]   w_beat_data;
  logic [1:0]             w_beat_be;

  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic                   r_ub_n, r_lb_n, r_we_n, r_oe_n, r_ce_n;
  logic [SRAM_DQ_W-1:0]   r_dq_out;
  logic                   r_dq_oe;
  logic [DATA_W-1:0]      r_rdata;

`ifdef SRAM_CTRL_BYTE_EN_EN
  assign w_be_in = mem_byte_en;
`else
  assign w_be_in = '1;
`endif

  assign w_req   = mem_r_en | mem_w_en;
  assign w_index = (mem_addr - 32'(BASE_ADDR)) >> BYTE_SHIFT;

  // NOTE: every signal written here gets a default first, so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_beat  = r_beat;
    w_next_wait  = r_wait;
    w_next_write = r_write;
    w_next_base  = r_base;
    w_next_wdata = r_wdata;
    w_next_be    = r_be;
    w_beat_end   = (r_wait == 4'(WAIT_CYCLES));
    w_last_beat  = (r_beat == BEAT_W'(BEATS - 1));
    mem_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        mem_ready = ~w_req;
        if (w_req) begin
          w_next_state = ST_ACCESS;
          w_next_beat  = '0;
          w_next_wait  = '0;
          w_next_write = mem_w_en;
          w_next_base  = SRAM_ADDR_W'(w_index * BEATS);
          w_next_wdata = mem_wdata;
          w_next_be    = w_be_in;
        end
      end
      ST_ACCESS: begin
        if (w_beat_end) begin
          w_next_wait = '0;
          if (w_last_beat) begin
            w_next_state = ST_DONE;
            w_next_beat  = '0;
          end else begin
            w_next_beat = r_beat + BEAT_W'(1);
          end
        end else begin
          w_next_wait = r_wait + 4'd1;
        end
      end
      ST_DONE: begin
        mem_ready    = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs for the upcoming cycle are derived from the next beat, so the SRAM pins come straight from flops.
  assign w_beat_data = w_next_wdata[w_next_beat*SRAM_DQ_W +: SRAM_DQ_W];
  assign w_beat_be   = w_next_be[w_next_beat*2 +: 2];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_wait  <= '0;
      r_write <= 1'b0;
      r_base  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next_state;
      r_beat  <= w_next_beat;
      r_wait  <= w_next_wait;
      r_write <= w_next_write;
      r_base  <= w_next_base;
      r_wdata <= w_next_wdata;
      r_be    <= w_next_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sram_addr <= '0;
      r_ce_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_ce_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_ub_n  <= 1'b1;
      r_lb_n  <= 1'b1;
      r_dq_oe <= 1'b0;
      if (w_next_state == ST_ACCESS) begin
        r_sram_addr <= w_next_base + SRAM_ADDR_W'(w_next_beat);
        r_ce_n      <= 1'b0;
        if (w_next_write) begin
          r_dq_oe  <= 1'b1;
          r_dq_out <= w_beat_data;
          r_we_n   <= ~|w_beat_be;
          r_ub_n   <= ~w_beat_be[1];
          r_lb_n   <= ~w_beat_be[0];
        end else begin
          r_oe_n <= 1'b0;
          r_ub_n <= 1'b0;
          r_lb_n <= 1'b0;
        end
      end
      if (r_state == ST_ACCESS && !r_write && w_beat_end)
        r_rdata[r_beat*SRAM_DQ_W +: SRAM_DQ_W] <= sram_dq;
    end
  end

  assign sram_dq   = r_dq_oe ? r_dq_out : {SRAM_DQ_W{1'bz}};
  assign sram_addr = r_sram_addr;
  assign sram_ce_n = r_ce_n;
  assign sram_we_n = r_we_n;
  assign sram_oe_n = r_oe_n;
  assign sram_ub_n = r_ub_n;
  assign sram_lb_n = r_lb_n;
  assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: two instances (WAIT_CYCLES=1 and 0) each backed by a small asynchronous SRAM model.
`timescale 1ns/1ps

module tb_sram_ctrl;

  localparam int DW  = 32;
  localparam int QW  = 16;
  localparam int AW  = 18;
  localparam int BEW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we_n;
    logic          oe_n;
    logic          ub_n;
    logic          lb_n;
    logic [QW-1:0] dq;
  } bus_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [7:0]    lat;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           sel, probe, bus_chk_en;
  logic           req_r, req_w;
  logic [31:0]    req_addr;
  logic [DW-1:0]  req_wdata;
  logic [BEW-1:0] req_be;

  logic          r_en0, w_en0, r_en1, w_en1;
  wire  [QW-1:0] dq0, dq1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] sa0, sa1;
  logic          rdy0, rdy1, ub0, lb0, we0, oe0, ce0, ub1, lb1, we1, oe1, ce1;

  assign r_en0 = !sel && req_r;
  assign w_en0 = !sel && req_w;
  assign r_en1 = sel && req_r;
  assign w_en1 = sel && req_w;

  sram_ctrl #(.WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r_en0), .mem_w_en(w_en0),
    .mem_addr(req_addr), .mem_wdata(req_wdata),
`ifdef SRAM_CTRL_BYTE_EN_EN
    .mem_byte_en(req_be),
`endif
    .mem_rdata(rdata0), .mem_ready(rdy0), .sram_dq(dq0), .sram_addr(sa0),
    .sram_ub_n(ub0), .sram_lb_n(lb0), .sram_we_n(we0), .sram_oe_n(oe0), .sram_ce_n(ce0)
  );

  sram_ctrl #(.WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en1), .mem_w_en(w_en1),
    .mem_addr(req_addr), .mem_wdata(req_wdata),
`ifdef SRAM_CTRL_BYTE_EN_EN
    .mem_byte_en(req_be),
`endif
    .mem_rdata(rdata1), .mem_ready(rdy1), .sram_dq(dq1), .sram_addr(sa1),
    .sram_ub_n(ub1), .sram_lb_n(lb1), .sram_we_n(we1), .sram_oe_n(oe1), .sram_ce_n(ce1)
  );

  // Asynchronous SRAM models; probe lets the bench see whether the controller has released dq.
  logic [QW-1:0] mem0 [64] = '{default: '0};
  logic [QW-1:0] mem1 [64] = '{default: '0};

  assign dq0 = (!ce0 && !oe0 && we0) ? mem0[sa0[5:0]] : (probe ? 16'hA55A : 16'hzzzz);
  assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1[5:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce0 && !we0) begin
      if (!lb0) mem0[sa0[5:0]][7:0]  <= dq0[7:0];
      if (!ub0) mem0[sa0[5:0]][15:8] <= dq0[15:8];
    end
    if (!ce1 && !we1) begin
      if (!lb1) mem1[sa1[5:0]][7:0]  <= dq1[7:0];
      if (!ub1) mem1[sa1[5:0]][15:8] <= dq1[15:8];
    end
  end

  logic          m_ready, m_ce, m_we, m_oe, m_ub, m_lb;
  logic [AW-1:0] m_addr;
  logic [QW-1:0] m_dq;
  logic [DW-1:0] m_rdata;

  always_comb begin
    m_ready = sel ? rdy1 : rdy0;
    m_ce    = sel ? ce1 : ce0;
    m_we    = sel ? we1 : we0;
    m_oe    = sel ? oe1 : oe0;
    m_ub    = sel ? ub1 : ub0;
    m_lb    = sel ? lb1 : lb0;
    m_addr  = sel ? sa1 : sa0;
    m_dq    = sel ? dq1 : dq0;
    m_rdata = sel ? rdata1 : rdata0;
  end

  bus_t  bus_q[$];
  resp_t resp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic exp_beats(input logic wr, input logic [AW-1:0] a0, input logic [DW-1:0] d,
                           input logic [BEW-1:0] be, input int len);
    bus_t       e;
    logic [1:0] s;
    for (int b = 0; b < 2; b++) begin
      s      = be[b*2 +: 2];
      e.addr = a0 + AW'(b);
      e.dq   = d[b*16 +: 16];
      if (wr) begin
        e.we_n = ~|s; e.oe_n = 1'b1; e.ub_n = ~s[1]; e.lb_n = ~s[0];
      end else begin
        e.we_n = 1'b1; e.oe_n = 1'b0; e.ub_n = 1'b0; e.lb_n = 1'b0;
      end
      for (int c = 0; c < len; c++) bus_q.push_back(e);
    end
  endtask

  task automatic exp_resp(input logic [DW-1:0] rdata, input int lat);
    resp_t r;
    r.rdata = rdata;
    r.lat   = 8'(lat);
    resp_q.push_back(r);
  endtask

  // Monitor: compares every active SRAM cycle and every completed request against the queues.
  int lat_cnt = 0;
  always @(negedge clk) begin
    bus_t  e, a;
    resp_t r;
    if (rst) begin
      lat_cnt = 0;
    end else begin
      if (bus_chk_en && !m_ce) begin
        if (bus_q.size() == 0) begin
          n_checks++;
          $display("FAIL bus_unexpected: got active beat at addr %h expected none", m_addr);
        end else begin
          e = bus_q.pop_front();
          a = {m_addr, m_we, m_oe, m_ub, m_lb, (e.we_n && e.oe_n) ? e.dq : m_dq};
          check("bus_beat", a, e);
        end
      end
      if (req_r || req_w) begin
        if (!m_ready) begin
          lat_cnt++;
        end else begin
          if (resp_q.size() == 0) begin
            n_checks++;
            $display("FAIL resp_unexpected: got mem_ready expected none");
          end else begin
            r = resp_q.pop_front();
            check("latency", 64'(lat_cnt), 64'(r.lat));
            check("rdata", m_rdata, r.rdata);
          end
          lat_cnt = 0;
        end
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [DW-1:0] wdata, input logic [BEW-1:0] be);
    bit done = 0;
    req_r = rd; req_w = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (m_ready) done = 1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL req_timeout: got no mem_ready for addr %h expected ready within 50 cycles", addr);
    end
    @(posedge clk); #1;
    req_r = 1'b0; req_w = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; probe = 1'b1; bus_chk_en = 1'b1;
    req_r = 1'b0; req_w = 1'b0; req_addr = '0; req_wdata = '0; req_be = '1;
    repeat (2) @(posedge clk); #1;
    check("rst_strobes", {ce0, we0, oe0, ub0, lb0}, 5'b11111);
    check("rst_addr", sa0, 0);
    check("rst_dq_released", dq0, 16'hA55A);
    check("rst_rdata", rdata0, 0);
    check("rst_ready", rdy0, 1);
    probe = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset during the second cycle of a write: beat 0 lands in SRAM, beat 1 never starts.
    bus_chk_en = 1'b0;
    req_w = 1'b1; req_addr = 32'd1024; req_wdata = 32'hCAFE1234;
    repeat (2) @(posedge clk); #1;
    check("pre_rst_we_n", we0, 0);
    rst = 1'b1; req_w = 1'b0; probe = 1'b1; #1;
    check("midrst_strobes", {ce0, we0, oe0, ub0, lb0}, 5'b11111);
    check("midrst_dq_released", dq0, 16'hA55A);
    check("midrst_ready", rdy0, 1);
    check("midrst_rdata", rdata0, 0);
    check("midrst_addr", sa0, 0);
    probe = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; bus_chk_en = 1'b1;

    exp_beats(0, 18'd0, 32'h00001234, '1, 2);  exp_resp(32'h00001234, 5);
    do_req(1, 0, 32'd1024, '0, '1);
    exp_beats(1, 18'd2, 32'hDEADBEEF, '1, 2);  exp_resp(32'h00001234, 5);
    do_req(0, 1, 32'd1028, 32'hDEADBEEF, '1);
    exp_beats(0, 18'd2, 32'hDEADBEEF, '1, 2);  exp_resp(32'hDEADBEEF, 5);
    do_req(1, 0, 32'd1028, '0, '1);
    exp_beats(1, 18'd4, 32'h12345678, '1, 2);  exp_resp(32'hDEADBEEF, 5);
    do_req(1, 1, 32'd1032, 32'h12345678, '1);
    exp_beats(0, 18'd4, 32'h12345678, '1, 2);  exp_resp(32'h12345678, 5);
    do_req(1, 0, 32'd1032, '0, '1);
    exp_beats(1, 18'h3FFFE, 32'h0BADF00D, '1, 2);  exp_resp(32'h12345678, 5);
    do_req(0, 1, 32'd1020, 32'h0BADF00D, '1);
    exp_beats(0, 18'h3FFFE, 32'h0BADF00D, '1, 2);  exp_resp(32'h0BADF00D, 5);
    do_req(1, 0, 32'd1020, '0, '1);

    repeat (3) @(posedge clk); #1;
    check("idle_ready", rdy0, 1);
    check("idle_strobes", {ce0, we0, oe0}, 3'b111);

    // Zero wait states, write immediately followed by read.
    sel = 1'b1;
    exp_beats(1, 18'd8, 32'h5A5AA5A5, '1, 1);  exp_resp(32'h00000000, 3);
    do_req(0, 1, 32'd1040, 32'h5A5AA5A5, '1);
    exp_beats(0, 18'd8, 32'h5A5AA5A5, '1, 1);  exp_resp(32'h5A5AA5A5, 3);
    do_req(1, 0, 32'd1040, '0, '1);

`ifdef SRAM_CTRL_BYTE_EN_EN
    exp_beats(1, 18'd0, 32'hAABBCCDD, 4'b0010, 1);  exp_resp(32'h5A5AA5A5, 3);
    do_req(0, 1, 32'd1024, 32'hAABBCCDD, 4'b0010);
    exp_beats(0, 18'd0, 32'h0000CC00, '1, 1);  exp_resp(32'h0000CC00, 3);
    do_req(1, 0, 32'd1024, '0, '1);
`endif

    repeat (3) @(posedge clk); #1;
    check("bus_q_drained", 64'(bus_q.size()), 0);
    check("resp_q_drained", 64'(resp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Parametrised bridge between the processor's MEM-stage memory request bus and the external asynchronous SRAM (16-bit DQ, active-low controls).
- Splits each DATA_W-bit word into DATA_W/SRAM_DQ_W SRAM beats with programmable wait states.
- Stalls the pipeline through mem_ready until the access completes.
- Replaces direct processor-to-SRAM wiring in the top level; sram_model stays the bench/board-side memory.

Parameters:
- DATA_W, 32: processor data width; integer multiple of SRAM_DQ_W.
- SRAM_DQ_W, 16: SRAM data bus width.
- SRAM_ADDR_W, 18: SRAM address width.
- WAIT_CYCLES, 1: extra cycles per beat; 0..15.
- BASE_ADDR, 1024: processor byte address mapped to SRAM word 0.

Ports:
- clk, input, 1: clock; single clock domain.
- rst, input, 1: reset, asynchronous, active-high.
- mem_r_en, input, 1: read request; held until mem_ready.
- mem_w_en, input, 1: write request; held until mem_ready.
- mem_addr, input, 32: byte address.
- mem_wdata, input, DATA_W: write data.
- mem_rdata, output, DATA_W: read data, registered.
- mem_ready, output, 1: 0 means stall the pipeline.
- sram_dq, inout, SRAM_DQ_W: SRAM data.
- sram_addr, output, SRAM_ADDR_W: SRAM word address.
- sram_ub_n, sram_lb_n, output, 1 each: byte masks.
- sram_we_n, sram_oe_n, sram_ce_n, output, 1 each: SRAM strobes.

Behaviour:
- BEATS = DATA_W/SRAM_DQ_W. BEAT_LEN = WAIT_CYCLES+1.
- Word index = (mem_addr - BASE_ADDR) >> log2(DATA_W/8). Beat address = index*BEATS + beat, truncated to SRAM_ADDR_W. Addresses below BASE_ADDR wrap modulo 2^SRAM_ADDR_W; no error is raised.
- Beat 0 carries the least-significant half-word.
- Reset values:
  - All SRAM strobes and masks = 1.
  - sram_addr = 0; sram_dq = Z.
  - mem_rdata = 0.
  - State = IDLE; beat and wait counters = 0.
- mem_ready = (IDLE and no request) or DONE. It is combinational from state and requests.
- FSM transitions:
  - IDLE -> ACCESS on mem_r_en or mem_w_en. Latch op, address and wdata.
  - If both requests are high, the access is a write.
  - ACCESS: each beat drives sram_addr, ce_n=0, ub_n=lb_n=0 for BEAT_LEN cycles.
  - ACCESS, write: we_n=0 and sram_dq driven for the whole beat.
  - ACCESS, read: oe_n=0 and sram_dq=Z. Data is sampled into the beat slice of mem_rdata on the last cycle of the beat.
  - ACCESS -> DONE after the last cycle of the last beat.
  - DONE: strobes return to 1, dq=Z, mem_ready=1 for exactly one cycle, then -> IDLE.
- Latency from request to mem_ready = 1 + BEATS*BEAT_LEN cycles (5 cycles for the defaults).
- Back-to-back requests: a request present in the cycle after DONE starts immediately. There is no extra bubble.
- A request dropped mid-access does not abort it; the access completes. Inputs are ignored until IDLE.
- All SRAM outputs are registered, so there is no glitching on the strobes.
- mem_rdata holds its value until the next read completes; writes do not alter it.
- rst asserted mid-access: abort immediately. Outputs take reset values, and a partial write is left in the SRAM.

Optional Feature:
- Macro: SRAM_CTRL_BYTE_EN_EN.
- Enabled:
  - Adds input mem_byte_en, width DATA_W/8.
  - For writes, each beat's ub_n/lb_n = inverted byte enables for its upper/lower byte.
  - A beat with both enables 0 still takes BEAT_LEN cycles with we_n=1.
  - Reads ignore mem_byte_en and use both masks = 0.
- Disabled: no port; masks are 0 for all beats.

Test Plan:
- Reset mid-write: assert rst in cycle 2 of a write to 1024 -> same cycle all strobes/masks = 1, dq = Z, mem_ready = 1 with no request, rdata = 0.
- Write 0xDEADBEEF to 1028 -> sram_addr 2 (dq 0xBEEF) for 2 cycles, then sram_addr 3 (dq 0xDEAD) for 2 cycles, we_n low throughout, mem_ready high in cycle 5 only.
- Read 1028 after that write -> oe_n low, dq Z from controller, mem_rdata = 0xDEADBEEF when mem_ready pulses.
- mem_r_en=mem_w_en=1, addr 1032, wdata 0x12345678 -> write to SRAM words 4/5; a subsequent read returns 0x12345678, and the prior mem_rdata is unchanged during the write.
- WAIT_CYCLES=0, back-to-back write then read at 1040 -> each beat lasts 1 cycle, mem_ready in cycle 3 of each access, the read starts in the cycle after DONE, readback matches.
- SRAM_CTRL_BYTE_EN_EN defined: mem_byte_en = 4'b0010, write 0xAABBCCDD at 1024 -> beat 0 ub_n=0, lb_n=1, we_n=0; beat 1 we_n=1. Readback = 0x0000CC00 over zero-initialised SRAM.
